acq_buffer_map: RTL

- VME-mapped, multi-channel circular acquisition buffer with trigger control.
- User logic streams G_NCHAN samples per valid cycle into per-channel dual-port RAMs.
- An FSM decides whether each sample is stored: idle, armed/pre-trigger, post-trigger count-down, done.
- VME reads control/status registers and the RAM contents; sits in the same bus map as the other cheby-style slaves.

---
 rtl/acq_buffer_pkg.sv | 31 +++
 rtl/acq_buffer_map_if.sv | 22 ++
 rtl/acq_buffer_fsm.sv | 99 +++++++++
 rtl/cheby_dpssram.sv | 27 ++
 rtl/acq_buffer_map.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/acq_buffer_pkg.sv
// Shared definitions for the VME-mapped acquisition buffer: register map,
// CTRL bit positions, acquisition state encoding and a clog2 helper.
package acq_buffer_pkg;

  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_STATUS   = 2'd1;
  localparam logic [1:0] REG_POST_LEN = 2'd2;
  localparam logic [1:0] REG_TRIG_POS = 2'd3;

  localparam int CTRL_ARM_BIT   = 0;
  localparam int CTRL_STOP_BIT  = 1;
  localparam int CTRL_CLEAR_BIT = 2;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    POST,
    DONE
  } acq_state_e;

  // Smallest r with 2**r >= n; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/acq_buffer_map_if.sv
// VME slave bus bundle shared by the cheby-style slaves of this bus map.
interface acq_buffer_map_if;

  logic [19:2] VMEAddr;
  logic [31:0] VMERdData;
  logic [31:0] VMEWrData;
  logic        VMERdMem;
  logic        VMEWrMem;
  logic        VMERdDone;
  logic        VMEWrDone;

  modport master (
    output VMEAddr, VMEWrData, VMERdMem, VMEWrMem,
    input  VMERdData, VMERdDone, VMEWrDone
  );

  modport slave (
    input  VMEAddr, VMEWrData, VMERdMem, VMEWrMem,
    output VMERdData, VMERdDone, VMEWrDone
  );

endinterface

// File: rtl/acq_buffer_fsm.sv
// Acquisition control: decides which valid samples are stored and tracks
// the write pointer, wrap flag, trigger position and post-trigger count.
module acq_buffer_fsm
  import acq_buffer_pkg::*;
#(
  parameter int G_DEPTH_LOG2 = 9
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    arm_i,
  input  logic                    stop_i,
  input  logic                    clear_i,
  input  logic                    acq_valid_i,
  input  logic                    acq_trig_i,
  input  logic [G_DEPTH_LOG2-1:0] post_len_i,
  output logic                    running_o,
  output logic                    done_o,
  output logic                    we_o,
  output logic [G_DEPTH_LOG2-1:0] waddr_o,
  output logic                    wrapped_o,
  output logic [G_DEPTH_LOG2-1:0] trig_pos_o
);

  localparam logic [G_DEPTH_LOG2-1:0] ONE      = G_DEPTH_LOG2'(1);
  localparam logic [G_DEPTH_LOG2-1:0] WPTR_MAX = '1;

  acq_state_e              state_q, state_d;
  logic [G_DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [G_DEPTH_LOG2-1:0] trig_pos_q, trig_pos_d;
  logic [G_DEPTH_LOG2-1:0] post_cnt_q, post_cnt_d;
  logic                    wrapped_q, wrapped_d;
  logic                    we;

  // State register; reset aborts any acquisition in progress.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      trig_pos_q <= '0;
      post_cnt_q <= '0;
      wrapped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      trig_pos_q <= trig_pos_d;
      post_cnt_q <= post_cnt_d;
      wrapped_q  <= wrapped_d;
    end
  end

  // Next state: clear beats stop beats arm; otherwise valid samples advance.
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    trig_pos_d = trig_pos_q;
    post_cnt_d = post_cnt_q;
    wrapped_d  = wrapped_q;
    we         = 1'b0;
    if (clear_i) begin
      state_d    = IDLE;
      wptr_d     = '0;
      wrapped_d  = 1'b0;
      trig_pos_d = '0;
      post_cnt_d = '0;
    end else if (stop_i) begin
      if (state_q == ARMED || state_q == POST) state_d = DONE;
    end else if (arm_i && (state_q == IDLE || state_q == DONE)) begin
      state_d   = ARMED;
      wptr_d    = '0;
      wrapped_d = 1'b0;
    end else if (acq_valid_i && (state_q == ARMED || state_q == POST)) begin
      we     = 1'b1;
      wptr_d = wptr_q + ONE;
      if (wptr_q == WPTR_MAX) wrapped_d = 1'b1;
      if (state_q == ARMED) begin
        if (acq_trig_i) begin
          trig_pos_d = wptr_q;
          if (post_len_i == '0) begin
            state_d = DONE;
          end else begin
            post_cnt_d = post_len_i;
            state_d    = POST;
          end
        end
      end else begin
        post_cnt_d = post_cnt_q - ONE;
        if (post_cnt_q == ONE) state_d = DONE;
      end
    end
  end

  assign running_o  = (state_q == ARMED) || (state_q == POST);
  assign done_o     = (state_q == DONE);
  assign we_o       = we;
  assign waddr_o    = wptr_q;
  assign wrapped_o  = wrapped_q;
  assign trig_pos_o = trig_pos_q;

endmodule

// File: rtl/cheby_dpssram.sv
// Simple dual-port RAM: write port for the acquisition side, registered
// read port for the VME side. Contents are never reset.
module cheby_dpssram #(
  parameter int G_DATA_W = 16,
  parameter int G_ADDR_W = 9
) (
  input  logic                clk_i,
  input  logic                wr_en_i,
  input  logic [G_ADDR_W-1:0] wr_addr_i,
  input  logic [G_DATA_W-1:0] wr_data_i,
  input  logic                rd_en_i,
  input  logic [G_ADDR_W-1:0] rd_addr_i,
  output logic [G_DATA_W-1:0] rd_data_o
);

  logic [G_DATA_W-1:0] mem_q [0:(1 << G_ADDR_W)-1];
  logic [G_DATA_W-1:0] rd_data_q;

  // Write on the acquisition port, synchronous read on the VME port.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/acq_buffer_map.sv
// VME-mapped multi-channel circular acquisition buffer: register decode,
// per-channel RAMs and a two-stage read pipeline (RAM read + output reg).
module acq_buffer_map
  import acq_buffer_pkg::*;
#(
  parameter int G_NCHAN      = 4,
  parameter int G_DATA_W     = 16,
  parameter int G_DEPTH_LOG2 = 9
) (
  input  logic                        Clk,
  input  logic                        rst_n,
  acq_buffer_map_if.slave             vme,
  input  logic                        acq_valid_i,
  input  logic [G_NCHAN*G_DATA_W-1:0] acq_data_i,
  input  logic                        acq_trig_i,
  output logic                        acq_running_o,
  output logic                        acq_done_o
);

  localparam int         CH_W    = clog2(G_NCHAN);
  localparam logic [4:0] CH_MASK = 5'((1 << CH_W) - 1);

  logic                    sel_mem;
  logic [1:0]              reg_idx;
  logic [G_DEPTH_LOG2-1:0] mem_idx;
  logic [17:0]             addr_shift;
  logic [4:0]              chan;
  logic                    wr_reg;
  logic                    arm, stop, clear;

  logic [G_DEPTH_LOG2-1:0] post_len_q;
  logic                    wr_done_q;
  logic                    running, done, we, wrapped;
  logic [G_DEPTH_LOG2-1:0] waddr, trig_pos;

  logic [G_DATA_W-1:0]     ram_rd [G_NCHAN];
  logic [31:0]             reg_word, mem_word;
  logic                    rd_pend_q, rd_mem_q;
  logic [4:0]              rd_chan_q;
  logic [31:0]             rd_reg_q;
  logic [31:0]             rd_data_q;
  logic                    rd_done_q;

  assign sel_mem    = vme.VMEAddr[19];
  assign reg_idx    = vme.VMEAddr[3:2];
  assign mem_idx    = vme.VMEAddr[G_DEPTH_LOG2+1:2];
  assign addr_shift = vme.VMEAddr >> G_DEPTH_LOG2;
  assign chan       = addr_shift[4:0] & CH_MASK;

  assign wr_reg = vme.VMEWrMem && !sel_mem;
  assign arm    = wr_reg && (reg_idx == REG_CTRL) && vme.VMEWrData[CTRL_ARM_BIT];
  assign stop   = wr_reg && (reg_idx == REG_CTRL) && vme.VMEWrData[CTRL_STOP_BIT];
  assign clear  = wr_reg && (reg_idx == REG_CTRL) && vme.VMEWrData[CTRL_CLEAR_BIT];

  // POST_LEN register and the one-cycle write acknowledge.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      post_len_q <= '0;
      wr_done_q  <= 1'b0;
    end else begin
      wr_done_q <= vme.VMEWrMem;
      if (wr_reg && reg_idx == REG_POST_LEN) post_len_q <= vme.VMEWrData[G_DEPTH_LOG2-1:0];
    end
  end

  acq_buffer_fsm #(.G_DEPTH_LOG2(G_DEPTH_LOG2)) u_fsm (
    .clk_i       (Clk),
    .rst_n_i     (rst_n),
    .arm_i       (arm),
    .stop_i      (stop),
    .clear_i     (clear),
    .acq_valid_i (acq_valid_i),
    .acq_trig_i  (acq_trig_i),
    .post_len_i  (post_len_q),
    .running_o   (running),
    .done_o      (done),
    .we_o        (we),
    .waddr_o     (waddr),
    .wrapped_o   (wrapped),
    .trig_pos_o  (trig_pos)
  );

  for (genvar k = 0; k < G_NCHAN; k++) begin : g_ram
    cheby_dpssram #(.G_DATA_W(G_DATA_W), .G_ADDR_W(G_DEPTH_LOG2)) u_ram (
      .clk_i     (Clk),
      .wr_en_i   (we),
      .wr_addr_i (waddr),
      .wr_data_i (acq_data_i[k*G_DATA_W +: G_DATA_W]),
      .rd_en_i   (vme.VMERdMem),
      .rd_addr_i (mem_idx),
      .rd_data_o (ram_rd[k])
    );
  end

  // Register read value for the currently addressed word.
  always_comb begin
    reg_word = '0;
    case (reg_idx)
      REG_CTRL:     reg_word = {30'b0, done, running};
      REG_STATUS:   reg_word = (32'(waddr) << 16) | {31'b0, wrapped};
      REG_POST_LEN: reg_word = 32'(post_len_q);
      REG_TRIG_POS: reg_word = 32'(trig_pos);
      default:      reg_word = '0;
    endcase
  end

  // Channel mux on the RAM outputs; unpopulated channels read as zero.
  always_comb begin
    mem_word = '0;
    for (int k = 0; k < G_NCHAN; k++) begin
      if (rd_chan_q == 5'(k)) mem_word = 32'(ram_rd[k]);
    end
  end

  // Two-stage read pipeline so registers and memory ack with equal latency.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q <= 1'b0;
      rd_mem_q  <= 1'b0;
      rd_chan_q <= '0;
      rd_reg_q  <= '0;
      rd_data_q <= '0;
      rd_done_q <= 1'b0;
    end else begin
      rd_pend_q <= vme.VMERdMem;
      rd_done_q <= rd_pend_q;
      if (vme.VMERdMem) begin
        rd_mem_q  <= sel_mem;
        rd_chan_q <= chan;
        rd_reg_q  <= reg_word;
      end
      if (rd_pend_q) rd_data_q <= rd_mem_q ? mem_word : rd_reg_q;
    end
  end

  assign vme.VMERdData  = rd_data_q;
  assign vme.VMERdDone  = rd_done_q;
  assign vme.VMEWrDone  = wr_done_q;
  assign acq_running_o  = running;
  assign acq_done_o     = done;

endmodule
